// File: rtl/flag_request_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | flag_request_queue_pkg                                                     |
// | Shared FSM encodings and saturating-counter helper for the request queue.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package flag_request_queue_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FIRE     = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

   // All-ones value for a counter of the given width.
   function automatic logic [31:0] sat_max(input int unsigned width);
      if (width >= 32) return 32'hFFFF_FFFF;
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flag_request_queue_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter                                                                |
// | Up-counter with synchronous clear that holds at all-ones.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sat_counter
   import flag_request_queue_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] c_MAX = WIDTH'(sat_max(WIDTH));

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != c_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/flag_request_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | flag_request_queue                                                         |
// | Queues request pulses and issues them one at a time as single-cycle flags  |
// | to a flag/ack crossing. Optional BUSY watchdog: FLAG_REQUEST_QUEUE_TIMEOUT_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module flag_request_queue
   import flag_request_queue_pkg::*;
#(
   parameter int CNT_WIDTH  = 8,
   parameter int LOST_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req,
   input  logic                  i_clear,
   input  logic                  i_busy,
   output logic                  o_flag_out,
   output logic [CNT_WIDTH-1:0]  o_pending,
   output logic                  o_empty,
   output logic                  o_full,
   output logic [LOST_WIDTH-1:0] o_lost_cnt,
   output logic                  o_timeout_err
);

   localparam logic [CNT_WIDTH-1:0] c_PEND_MAX = CNT_WIDTH'(sat_max(CNT_WIDTH));

   state_t               r_state;
   logic                 r_flag_out;
   logic [CNT_WIDTH-1:0] r_pending;

   logic w_empty;
   logic w_full;
   logic w_issue;
   logic w_accept;
   logic w_lost_inc;

   assign w_empty    = (r_pending == '0);
   assign w_full     = (r_pending == c_PEND_MAX);
   assign w_issue    = (r_state == ST_IDLE) && !w_empty && !i_busy;
   // A request hitting a full queue still fits if a slot frees on the same edge.
   assign w_accept   = i_req && (!w_full || w_issue);
   assign w_lost_inc = i_req && w_full && !w_issue;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_flag_out <= 1'b0;
      end else if (i_clear) begin
         r_state    <= ST_IDLE;
         r_flag_out <= 1'b0;
      end else begin
         r_flag_out <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_state    <= ST_FIRE;
                  r_flag_out <= 1'b1;
               end
            end
            ST_FIRE:     r_state <= ST_WAIT_ACK;
            ST_WAIT_ACK: if (!i_busy) r_state <= ST_IDLE;
            default:     r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else if (i_clear) begin
         r_pending <= '0;
      end else if (w_accept && !w_issue) begin
         r_pending <= r_pending + 1'b1;
      end else if (!w_accept && w_issue) begin
         r_pending <= r_pending - 1'b1;
      end
   end

   sat_counter #(
      .WIDTH (LOST_WIDTH)
   ) u_lost_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (i_clear),
      .i_inc   (w_lost_inc),
      .o_count (o_lost_cnt)
   );

`ifdef FLAG_REQUEST_QUEUE_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT + 1);

   logic [c_TO_W-1:0] w_to_count;
   logic              r_timeout_err;

   sat_counter #(
      .WIDTH (c_TO_W)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (i_clear || (r_state != ST_WAIT_ACK)),
      .i_inc   (r_state == ST_WAIT_ACK),
      .o_count (w_to_count)
   );

   // The count holds completed WAIT_ACK cycles, so TIMEOUT-1 marks the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout_err <= 1'b0;
      end else if (i_clear) begin
         r_timeout_err <= 1'b0;
      end else if ((r_state == ST_WAIT_ACK) && i_busy &&
                   (w_to_count == c_TO_W'(TIMEOUT - 1))) begin
         r_timeout_err <= 1'b1;
      end
   end

   assign o_timeout_err = r_timeout_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT;
   assign o_timeout_err    = 1'b0;
`endif

   assign o_flag_out = r_flag_out;
   assign o_pending  = r_pending;
   assign o_empty    = w_empty;
   assign o_full     = w_full;

endmodule
`default_nettype wire

// File: tb/tb_flag_request_queue.sv
`default_nettype none
// Directed bench: instance A (default sizes) sits behind a modelled crossing,
// instance S (2-bit queue, TIMEOUT=8) has BUSY driven directly.
module tb_flag_request_queue;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        req_a = 1'b0, clear_a = 1'b0, busy_a;
   logic        flag_a, empty_a, full_a, err_a;
   logic [7:0]  pending_a;
   logic [15:0] lost_a;

   logic        req_s = 1'b0, clear_s = 1'b0, busy_s = 1'b0;
   logic        flag_s, empty_s, full_s, err_s;
   logic [1:0]  pending_s;
   logic [15:0] lost_s;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   flag_request_queue dut_a (
      .clk (clk), .rst_n (rst_n), .i_req (req_a), .i_clear (clear_a), .i_busy (busy_a),
      .o_flag_out (flag_a), .o_pending (pending_a), .o_empty (empty_a), .o_full (full_a),
      .o_lost_cnt (lost_a), .o_timeout_err (err_a)
   );

   flag_request_queue #(.CNT_WIDTH(2), .LOST_WIDTH(16), .TIMEOUT(8)) dut_s (
      .clk (clk), .rst_n (rst_n), .i_req (req_s), .i_clear (clear_s), .i_busy (busy_s),
      .o_flag_out (flag_s), .o_pending (pending_s), .o_empty (empty_s), .o_full (full_s),
      .o_lost_cnt (lost_s), .o_timeout_err (err_s)
   );

   // Crossing model: BUSY rises the edge after the flag and stays high 3 cycles.
   logic [1:0] r_bcnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_bcnt <= 2'd0;
      else if (flag_a)       r_bcnt <= 2'd3;
      else if (r_bcnt != 0)  r_bcnt <= r_bcnt - 2'd1;
   end
   assign busy_a = (r_bcnt != 2'd0);

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (flag_a !== 1'b0)     begin n_errors++; $display("FAIL rst_flag_a got %0b exp 0", flag_a); end
      n_checks++; if (pending_a !== 8'd0)  begin n_errors++; $display("FAIL rst_pending_a got %0d exp 0", pending_a); end
      n_checks++; if (empty_a !== 1'b1)    begin n_errors++; $display("FAIL rst_empty_a got %0b exp 1", empty_a); end
      n_checks++; if (full_a !== 1'b0)     begin n_errors++; $display("FAIL rst_full_a got %0b exp 0", full_a); end
      n_checks++; if (lost_a !== 16'd0)    begin n_errors++; $display("FAIL rst_lost_a got %0d exp 0", lost_a); end
      n_checks++; if (err_a !== 1'b0)      begin n_errors++; $display("FAIL rst_err_a got %0b exp 0", err_a); end
      n_checks++; if (pending_s !== 2'd0)  begin n_errors++; $display("FAIL rst_pending_s got %0d exp 0", pending_s); end
      n_checks++; if (full_s !== 1'b0)     begin n_errors++; $display("FAIL rst_full_s got %0b exp 0", full_s); end
      n_checks++; if (err_s !== 1'b0)      begin n_errors++; $display("FAIL rst_err_s got %0b exp 0", err_s); end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single;
      @(negedge clk) req_a = 1'b1;
      @(posedge clk) #1;
      n_checks++; if (pending_a !== 8'd1) begin n_errors++; $display("FAIL single_pend1 got %0d exp 1", pending_a); end
      n_checks++; if (flag_a !== 1'b0)    begin n_errors++; $display("FAIL single_flag_early got %0b exp 0", flag_a); end
      @(negedge clk) req_a = 1'b0;
      @(posedge clk) #1;
      n_checks++; if (flag_a !== 1'b1)    begin n_errors++; $display("FAIL single_flag got %0b exp 1", flag_a); end
      n_checks++; if (pending_a !== 8'd0) begin n_errors++; $display("FAIL single_pend0 got %0d exp 0", pending_a); end
      @(posedge clk) #1;
      n_checks++; if (flag_a !== 1'b0)    begin n_errors++; $display("FAIL single_width got %0b exp 0", flag_a); end
      n_checks++; if (busy_a !== 1'b1)    begin n_errors++; $display("FAIL single_busy got %0b exp 1", busy_a); end
      repeat (8) @(negedge clk);
      n_checks++; if (empty_a !== 1'b1)   begin n_errors++; $display("FAIL single_empty got %0b exp 1", empty_a); end
   endtask

   task automatic test_burst;
      int n_fl = 0, n_bad = 0, peak = 0;
      @(negedge clk) req_a = 1'b1;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (i == 9) req_a = 1'b0;
         if (flag_a) n_fl++;
         if (flag_a && busy_a) n_bad++;
         if (int'(pending_a) > peak) peak = int'(pending_a);
      end
      n_checks++; if (n_fl != 10)         begin n_errors++; $display("FAIL burst_flags got %0d exp 10", n_fl); end
      n_checks++; if (n_bad != 0)         begin n_errors++; $display("FAIL burst_flag_while_busy got %0d exp 0", n_bad); end
      n_checks++; if (peak < 2)           begin n_errors++; $display("FAIL burst_peak got %0d exp >=2", peak); end
      n_checks++; if (pending_a !== 8'd0) begin n_errors++; $display("FAIL burst_drain got %0d exp 0", pending_a); end
      n_checks++; if (lost_a !== 16'd0)   begin n_errors++; $display("FAIL burst_lost got %0d exp 0", lost_a); end
   endtask

   task automatic test_saturate;
      int n_fl = 0;
      @(negedge clk) begin busy_s = 1'b1; req_s = 1'b1; end
      repeat (5) @(negedge clk);
      req_s = 1'b0;
      n_checks++; if (pending_s !== 2'd3) begin n_errors++; $display("FAIL sat_pending got %0d exp 3", pending_s); end
      n_checks++; if (full_s !== 1'b1)    begin n_errors++; $display("FAIL sat_full got %0b exp 1", full_s); end
      n_checks++; if (lost_s !== 16'd2)   begin n_errors++; $display("FAIL sat_lost got %0d exp 2", lost_s); end
      n_checks++; if (flag_s !== 1'b0)    begin n_errors++; $display("FAIL sat_flag_busy got %0b exp 0", flag_s); end
      busy_s = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (flag_s) n_fl++;
      end
      n_checks++; if (n_fl != 3)          begin n_errors++; $display("FAIL sat_drain_flags got %0d exp 3", n_fl); end
      n_checks++; if (empty_s !== 1'b1)   begin n_errors++; $display("FAIL sat_empty got %0b exp 1", empty_s); end
   endtask

   task automatic test_full_fire;
      busy_s = 1'b1; req_s = 1'b1;
      repeat (3) @(negedge clk);
      busy_s = 1'b0;
      @(posedge clk) #1;
      n_checks++; if (flag_s !== 1'b1)    begin n_errors++; $display("FAIL ff_flag got %0b exp 1", flag_s); end
      n_checks++; if (pending_s !== 2'd3) begin n_errors++; $display("FAIL ff_pending got %0d exp 3", pending_s); end
      n_checks++; if (lost_s !== 16'd2)   begin n_errors++; $display("FAIL ff_lost got %0d exp 2", lost_s); end
      @(negedge clk) begin req_s = 1'b0; busy_s = 1'b1; end
   endtask

   task automatic test_clear;
      int n_fl = 0;
      clear_s = 1'b1;
      @(negedge clk) clear_s = 1'b0;
      n_checks++; if (pending_s !== 2'd0) begin n_errors++; $display("FAIL clr0_pending got %0d exp 0", pending_s); end
      n_checks++; if (lost_s !== 16'd0)   begin n_errors++; $display("FAIL clr0_lost got %0d exp 0", lost_s); end
      req_s = 1'b1;
      repeat (4) @(negedge clk);
      req_s = 1'b0; busy_s = 1'b0;
      @(negedge clk);
      n_checks++; if (flag_s !== 1'b1)    begin n_errors++; $display("FAIL clr_issue got %0b exp 1", flag_s); end
      busy_s = 1'b1;
      @(negedge clk);
      n_checks++; if (pending_s !== 2'd2) begin n_errors++; $display("FAIL clr_pre_pending got %0d exp 2", pending_s); end
      n_checks++; if (lost_s !== 16'd1)   begin n_errors++; $display("FAIL clr_pre_lost got %0d exp 1", lost_s); end
      clear_s = 1'b1;
      @(posedge clk) #1;
      n_checks++; if (pending_s !== 2'd0) begin n_errors++; $display("FAIL clr_pending got %0d exp 0", pending_s); end
      n_checks++; if (lost_s !== 16'd0)   begin n_errors++; $display("FAIL clr_lost got %0d exp 0", lost_s); end
      @(negedge clk) begin clear_s = 1'b0; busy_s = 1'b0; end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (flag_s) n_fl++;
      end
      n_checks++; if (n_fl != 0)          begin n_errors++; $display("FAIL clr_no_flag got %0d exp 0", n_fl); end
   endtask

`ifdef FLAG_REQUEST_QUEUE_TIMEOUT_EN
   task automatic test_timeout;
      bit seen = 1'b0;
      busy_s = 1'b1; req_s = 1'b1;
      repeat (2) @(negedge clk);
      req_s = 1'b0; busy_s = 1'b0;
      @(negedge clk);
      n_checks++; if (flag_s !== 1'b1)    begin n_errors++; $display("FAIL to_issue got %0b exp 1", flag_s); end
      busy_s = 1'b1;
      @(negedge clk);
      repeat (7) @(negedge clk);
      n_checks++; if (err_s !== 1'b0)     begin n_errors++; $display("FAIL to_early got %0b exp 0", err_s); end
      @(negedge clk);
      n_checks++; if (err_s !== 1'b1)     begin n_errors++; $display("FAIL to_set got %0b exp 1", err_s); end
      busy_s = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (flag_s) seen = 1'b1;
      end
      n_checks++; if (!seen)              begin n_errors++; $display("FAIL to_resume got 0 exp 1"); end
      n_checks++; if (pending_s !== 2'd0) begin n_errors++; $display("FAIL to_pending got %0d exp 0", pending_s); end
      n_checks++; if (err_s !== 1'b1)     begin n_errors++; $display("FAIL to_sticky got %0b exp 1", err_s); end
      repeat (4) @(negedge clk);
      clear_s = 1'b1;
      @(negedge clk) clear_s = 1'b0;
      n_checks++; if (err_s !== 1'b0)     begin n_errors++; $display("FAIL to_clear got %0b exp 0", err_s); end
   endtask
`endif

   task automatic test_reset_mid;
      busy_s = 1'b1; req_s = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (pending_s !== 2'd2) begin n_errors++; $display("FAIL mid_pre got %0d exp 2", pending_s); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (pending_s !== 2'd0) begin n_errors++; $display("FAIL mid_pending got %0d exp 0", pending_s); end
      n_checks++; if (empty_s !== 1'b1)   begin n_errors++; $display("FAIL mid_empty got %0b exp 1", empty_s); end
      @(negedge clk) begin req_s = 1'b0; busy_s = 1'b0; rst_n = 1'b1; end
      repeat (5) @(negedge clk);
      n_checks++; if (flag_s !== 1'b0)    begin n_errors++; $display("FAIL mid_noflag got %0b exp 0", flag_s); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_saturate();
      test_full_fire();
      test_clear();
`ifdef FLAG_REQUEST_QUEUE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
